// File: rtl/regfile_write_arbiter_pkg.sv
// Shared writeback types: register/data widths, the queued entry format
// and a one-hot register decode used to build the pending scoreboard.
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two producers, the hold input and the register
// file write port.
//
// Handshake: a producer request is taken on a rising edge exactly when its
// valid and ready are both high at that edge. Ready never depends on the
// producer's own valid (md_ready) or only on md_valid (alu_ready), so there
// is no combinational loop. A request that is not taken must be held by the
// producer until it is.
interface regfile_write_arbiter_if
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                    alu_valid;
    logic [REG_ADDR_W-1:0]   alu_reg;
    logic [DATA_W-1:0]       alu_data;
    logic                    alu_ready;

    logic                    md_valid;
    logic [REG_ADDR_W-1:0]   md_reg;
    logic [DATA_W-1:0]       md_data;
    logic                    md_ready;

    logic                    wr_hold;

    logic                    ctrl_writeEnable;
    logic [REG_ADDR_W-1:0]   ctrl_writeReg;
    logic [DATA_W-1:0]       data_writeReg;
    logic [NUM_REGS-1:0]     pending;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport master (
        output alu_valid, alu_reg, alu_data,
        input  alu_ready,
        output md_valid, md_reg, md_data,
        input  md_ready,
        output wr_hold,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending, fifo_count
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        output alu_ready,
        input  md_valid, md_reg, md_data,
        output md_ready,
        input  wr_hold,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending, fifo_count
    );

endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Synchronous writeback FIFO. Pointers wrap modulo DEPTH (power of two).
// Per-slot valid bits and destination addresses are exported so the
// arbiter can compute which registers still have writes in flight.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH-1:0]       entry_valid,
    output logic [REG_ADDR_W-1:0]  entry_addr [DEPTH]
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wb_entry_t          mem_q [DEPTH];
    wb_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state: write at wptr, retire at rptr, occupancy tracks both.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        if (do_push) begin
            mem_d[wptr_q]   = push_entry;
            valid_d[wptr_q] = 1'b1;
            wptr_d          = wptr_q + 1'b1;
        end
        if (do_pop) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // State register; reset clears storage as well so nothing relies on power-up values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Export head entry and per-slot destination addresses.
    always_comb begin
        head        = mem_q[rptr_q];
        count       = count_q;
        entry_valid = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem_q[i].addr;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file writeback arbiter: mult/div has fixed priority over the ALU,
// writes to r0 are swallowed, accepted writes are buffered in a FIFO and
// drained one per cycle into a registered write port unless wr_hold is set.
// pending[] marks every register with a write still queued or on the port.
module regfile_write_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    regfile_write_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    wb_entry_t              fifo_head;
    logic [DEPTH-1:0]       fifo_valid;
    logic [REG_ADDR_W-1:0]  fifo_addr [DEPTH];

    logic                   can_accept;
    logic                   md_ready;
    logic                   alu_ready;
    logic                   md_take;
    logic                   alu_take;
    wb_entry_t              sel_entry;
    logic                   push;
    logic                   pop;

    logic                   we_q, we_d;
    logic [REG_ADDR_W-1:0]  wreg_q, wreg_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [NUM_REGS-1:0]    pending;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clock),
        .rst         (ctrl_reset),
        .push        (push),
        .push_entry  (sel_entry),
        .pop         (pop),
        .head        (fifo_head),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (fifo_valid),
        .entry_addr  (fifo_addr)
    );

    // Arbitration: ready comes from registered occupancy only (no push-through-pop),
    // md wins; r0 requests complete the handshake but are not stored.
    always_comb begin
        can_accept = !fifo_full && !ctrl_reset;
        md_ready   = can_accept;
        alu_ready  = can_accept && !bus.md_valid;
        md_take    = bus.md_valid && md_ready;
        alu_take   = bus.alu_valid && alu_ready;
        if (md_take) begin
            sel_entry = '{addr: bus.md_reg, data: bus.md_data};
        end else begin
            sel_entry = '{addr: bus.alu_reg, data: bus.alu_data};
        end
        push = (md_take || alu_take) && (sel_entry.addr != '0);
        pop  = !fifo_empty && !bus.wr_hold && !ctrl_reset;
    end

    // Output register next-state: load the FIFO head on a pop, otherwise hold address/data.
    always_comb begin
        we_d    = pop;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (pop) begin
            wreg_d  = fifo_head.addr;
            wdata_d = fifo_head.data;
        end
    end

    // Output register state.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    // Pending scoreboard: every live FIFO slot plus the write port when active; r0 never pending.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) begin
                pending = pending | reg_onehot(fifo_addr[i]);
            end
        end
        if (we_q) begin
            pending = pending | reg_onehot(wreg_q);
        end
        pending[0] = 1'b0;
    end

    assign bus.md_ready         = md_ready;
    assign bus.alu_ready        = alu_ready;
    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;
    assign bus.pending          = pending;
    assign bus.fifo_count       = fifo_count;

endmodule
